blackparrot_fpga_host_axil_nbf_bridge: RTL and testbench

AXI4-Lite slave that terminates host (PCIe/PS) register traffic and turns writes to a data register into a 32b ready/valid word stream. That stream is the NBF flit stream consumed by the NBF deserializer/AXI-master stage.
Provides status (FIFO free slots, pushed-word count, sticky error) and control (flush, error clear) so host software can pace NBF loading.
Sits between the host AXIL interconnect and the NBF stage's nbf_v_i/nbf_data_i/nbf_ready_and_o port.

---
 rtl/blackparrot_fpga_host_axil_nbf_bridge_pkg.sv | 14 +
 rtl/blackparrot_fpga_host_axil_nbf_bridge_if.sv | 32 +++
 rtl/blackparrot_fpga_host_axil_nbf_bridge_fifo.sv | 46 ++++
 rtl/blackparrot_fpga_host_axil_nbf_bridge.sv | 86 ++++++++
 tb/tb_blackparrot_fpga_host_axil_nbf_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blackparrot_fpga_host_axil_nbf_bridge_pkg.sv
// blackparrot_fpga_host_pkg: register map, AXIL response codes and status layout for the host NBF bridge
package blackparrot_fpga_host_pkg;
  localparam logic [3:0] OFF_DATA    = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_PUSHCNT = 4'h8;
  localparam logic [3:0] OFF_CTRL    = 4'hC;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef struct packed {
    logic        err;
    logic [21:0] rsvd;
    logic [8:0]  free;
  } status_t;
endpackage

// File: rtl/blackparrot_fpga_host_axil_nbf_bridge_if.sv
// blackparrot_fpga_host_axil_nbf_bridge_if: AXI4-Lite bus between host interconnect and the NBF bridge
interface blackparrot_fpga_host_axil_nbf_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axil_awaddr;
  logic [2:0]          s_axil_awprot;
  logic                s_axil_awvalid, s_axil_awready;
  logic [DATA_W-1:0]   s_axil_wdata;
  logic [DATA_W/8-1:0] s_axil_wstrb;
  logic                s_axil_wvalid, s_axil_wready;
  logic [1:0]          s_axil_bresp;
  logic                s_axil_bvalid, s_axil_bready;
  logic [ADDR_W-1:0]   s_axil_araddr;
  logic [2:0]          s_axil_arprot;
  logic                s_axil_arvalid, s_axil_arready;
  logic [DATA_W-1:0]   s_axil_rdata;
  logic [1:0]          s_axil_rresp;
  logic                s_axil_rvalid, s_axil_rready;
  modport slave (
    input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
           s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
  modport master (
    output s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
           s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/blackparrot_fpga_host_axil_nbf_bridge_fifo.sv
// bsg_fifo_1r1w_small: registered circular FIFO with count output and a synchronous clear
module bsg_fifo_1r1w_small #(
  parameter int width_p = 32,
  parameter int els_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic [$clog2(els_p):0]   count_o
);
  localparam int ptr_w = $clog2(els_p);
  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ptr_w:0] count_q, count_d;
  logic push, pop;
  assign ready_o = count_q != (ptr_w+1)'(els_p);
  assign v_o     = count_q != '0;
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  // clear beats any concurrent pop so the stream restarts empty
  always_comb begin
    rptr_d  = clear_i ? '0 : rptr_q + ptr_w'(pop);
    wptr_d  = clear_i ? '0 : wptr_q + ptr_w'(push);
    count_d = clear_i ? '0 : count_q + (ptr_w+1)'(push) - (ptr_w+1)'(pop);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk_i)
    if (push) mem_q[wptr_q] <= data_i;
endmodule

// File: rtl/blackparrot_fpga_host_axil_nbf_bridge.sv
// blackparrot_fpga_host_axil_nbf_bridge: AXIL slave turning DATA register writes into the NBF word stream,
// with status/pushcount readback and flush/error-clear control for host pacing.
module blackparrot_fpga_host_axil_nbf_bridge
  import blackparrot_fpga_host_pkg::*;
#(
  parameter int S_AXIL_ADDR_WIDTH = 32,
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int fifo_data_width_p = 32,
  parameter int fifo_els_p        = 16
) (
  input  logic                                  s_axil_aclk,
  input  logic                                  s_axil_aresetn,
  blackparrot_fpga_host_axil_nbf_bridge_if.slave axil,
  output logic                                  nbf_v_o,
  output logic [fifo_data_width_p-1:0]          nbf_data_o,
  input  logic                                  nbf_ready_and_i
);
  logic [3:0] woff, roff;
  logic fifo_ready, w_acc, r_acc, w_bad, r_err, push, flush, clr_err;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, pushcnt_q, pushcnt_d;
  logic [$clog2(fifo_els_p):0] count;
  logic unused_bits;
  status_t status;
  assign unused_bits = ^{axil.s_axil_awprot, axil.s_axil_arprot, axil.s_axil_awaddr, axil.s_axil_araddr};
  assign woff = axil.s_axil_awaddr[3:0];
  assign roff = axil.s_axil_araddr[3:0];
  // a DATA write only stalls when the FIFO is full; every other offset completes immediately
  assign w_acc   = s_axil_aresetn & axil.s_axil_awvalid & axil.s_axil_wvalid & ~bvalid_q
                 & ~(woff == OFF_DATA & ~fifo_ready);
  assign r_acc   = s_axil_aresetn & axil.s_axil_arvalid & ~rvalid_q;
  assign w_bad   = ~((woff == OFF_DATA & axil.s_axil_wstrb == 4'hF) | woff inside {OFF_STATUS, OFF_PUSHCNT, OFF_CTRL});
  assign r_err   = ~(roff inside {OFF_DATA, OFF_STATUS, OFF_PUSHCNT, OFF_CTRL});
  assign push    = w_acc & woff == OFF_DATA & axil.s_axil_wstrb == 4'hF;
  assign flush   = w_acc & woff == OFF_CTRL & axil.s_axil_wdata[0];
  assign clr_err = w_acc & woff == OFF_CTRL & axil.s_axil_wdata[1];
  assign status  = '{err: err_q, rsvd: '0, free: 9'(fifo_els_p) - 9'(count)};
  always_comb begin
    bvalid_d  = w_acc | (bvalid_q & ~axil.s_axil_bready);
    bresp_d   = w_acc ? (w_bad ? RESP_SLVERR : RESP_OKAY) : bresp_q;
    rvalid_d  = r_acc | (rvalid_q & ~axil.s_axil_rready);
    rresp_d   = r_acc ? (r_err ? RESP_SLVERR : RESP_OKAY) : rresp_q;
    rdata_d   = !r_acc ? rdata_q : roff == OFF_STATUS ? status : roff == OFF_PUSHCNT ? pushcnt_q : '0;
    err_d     = (w_acc & w_bad) | (r_acc & r_err) | (err_q & ~clr_err);
    pushcnt_d = pushcnt_q + 32'(push);
  end
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn)
    if (!s_axil_aresetn) begin
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      pushcnt_q <= '0;
    end else begin
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      pushcnt_q <= pushcnt_d;
    end
  assign axil.s_axil_awready = w_acc;
  assign axil.s_axil_wready  = w_acc;
  assign axil.s_axil_bvalid  = bvalid_q;
  assign axil.s_axil_bresp   = bresp_q;
  assign axil.s_axil_arready = r_acc;
  assign axil.s_axil_rvalid  = rvalid_q;
  assign axil.s_axil_rresp   = rresp_q;
  assign axil.s_axil_rdata   = rdata_q;
  bsg_fifo_1r1w_small #(.width_p(fifo_data_width_p), .els_p(fifo_els_p)) u_fifo (
    .clk_i(s_axil_aclk),
    .reset_n_i(s_axil_aresetn),
    .clear_i(flush),
    .v_i(push),
    .data_i(axil.s_axil_wdata),
    .ready_o(fifo_ready),
    .v_o(nbf_v_o),
    .data_o(nbf_data_o),
    .yumi_i(nbf_ready_and_i),
    .count_o(count)
  );
endmodule

// File: tb/tb_blackparrot_fpga_host_axil_nbf_bridge.sv
// tb_blackparrot_fpga_host_axil_nbf_bridge: scenario tasks drive AXIL traffic; a scoreboard queue
// holds expected NBF words and a monitor pops/compares them as the stream delivers.
module tb_blackparrot_fpga_host_axil_nbf_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  blackparrot_fpga_host_axil_nbf_bridge_if #(.ADDR_W(32), .DATA_W(32)) axil ();
  logic nbf_v, nbf_ready;
  logic [31:0] nbf_data;
  blackparrot_fpga_host_axil_nbf_bridge #(
    .S_AXIL_ADDR_WIDTH(32), .S_AXIL_DATA_WIDTH(32), .fifo_data_width_p(32), .fifo_els_p(16)
  ) u_dut (
    .s_axil_aclk(clk),
    .s_axil_aresetn(rst_n),
    .axil(axil.slave),
    .nbf_v_o(nbf_v),
    .nbf_data_o(nbf_data),
    .nbf_ready_and_i(nbf_ready)
  );
  int checks = 0;
  int errors = 0;
  int exp_pcnt = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  always @(negedge clk)
    if (rst_n && nbf_v && nbf_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL nbf_unexpected got=%h exp=none", nbf_data);
      end else begin
        mon_exp = sb.pop_front();
        if (nbf_data !== mon_exp) begin
          errors++;
          $display("FAIL nbf_data got=%h exp=%h", nbf_data, mon_exp);
        end
      end
    end

  task automatic aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output bit ok);
    @(posedge clk); #1;
    axil.s_axil_awaddr = addr; axil.s_axil_wdata = data; axil.s_axil_wstrb = strb;
    axil.s_axil_awvalid = 1'b1; axil.s_axil_wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axil.s_axil_awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axil.s_axil_awvalid = 1'b0; axil.s_axil_wvalid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL aw_accept got=timeout exp=accept addr=%h", addr); end
  endtask

  task automatic b_wait(output logic [1:0] resp);
    axil.s_axil_bready = 1'b1;
    resp = 2'bxx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axil.s_axil_bvalid) begin resp = axil.s_axil_bresp; break; end
    end
    @(posedge clk); #1;
    axil.s_axil_bready = 1'b0;
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output logic [1:0] resp);
    bit ok;
    aw_w(addr, data, strb, ok);
    b_wait(resp);
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    @(posedge clk); #1;
    axil.s_axil_araddr = addr; axil.s_axil_arvalid = 1'b1;
    data = 'x; resp = 'x; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axil.s_axil_arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axil.s_axil_arvalid = 1'b0;
    if (!ok) return;
    axil.s_axil_rready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axil.s_axil_rvalid) begin data = axil.s_axil_rdata; resp = axil.s_axil_rresp; break; end
    end
    @(posedge clk); #1;
    axil.s_axil_rready = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !nbf_v) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL drain got=%0d_left exp=0_left", sb.size()); end
  endtask

  task automatic test_reset();
    axil.s_axil_awvalid = 1'b1; axil.s_axil_wvalid = 1'b1; axil.s_axil_arvalid = 1'b1;
    axil.s_axil_awaddr = '0; axil.s_axil_araddr = '0; axil.s_axil_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    checks += 5;
    if (nbf_v !== 1'b0) begin errors++; $display("FAIL rst_nbf_v got=%b exp=0", nbf_v); end
    if (axil.s_axil_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got=%b exp=0", axil.s_axil_bvalid); end
    if (axil.s_axil_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", axil.s_axil_rvalid); end
    if (axil.s_axil_awready !== 1'b0) begin errors++; $display("FAIL rst_awready got=%b exp=0", axil.s_axil_awready); end
    if (axil.s_axil_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got=%b exp=0", axil.s_axil_arready); end
    axil.s_axil_awvalid = 1'b0; axil.s_axil_wvalid = 1'b0; axil.s_axil_arvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [1:0] r;
    logic [31:0] d;
    nbf_ready = 1'b0;
    checks++;
    if (nbf_v !== 1'b0) begin errors++; $display("FAIL basic_pre_v got=%b exp=0", nbf_v); end
    sb.push_back(32'h3);
    aw_w(32'h0, 32'h3, 4'hF, ok);
    checks += 2;
    if (nbf_v !== 1'b1) begin errors++; $display("FAIL basic_latency_v got=%b exp=1", nbf_v); end
    if (nbf_data !== 32'h3) begin errors++; $display("FAIL basic_latency_data got=%h exp=00000003", nbf_data); end
    b_wait(r);
    exp_pcnt++;
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp got=%b exp=00", r); end
    axil_read(32'h8, d, r);
    checks++;
    if (d !== 32'(exp_pcnt) || r !== 2'b00) begin errors++; $display("FAIL basic_pushcnt got=%h/%b exp=%h/00", d, r, exp_pcnt); end
    axil_read(32'h0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL data_read got=%h/%b exp=0/00", d, r); end
    axil_read(32'hC, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL ctrl_read got=%h/%b exp=0/00", d, r); end
    nbf_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_stall();
    logic [1:0] r;
    logic [31:0] d;
    int stalled = 0;
    bit ok = 1'b0;
    nbf_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(32'h1000 + 32'(i));
      axil_write(32'h0, 32'h1000 + 32'(i), 4'hF, r);
      checks++;
      if (r !== 2'b00) begin errors++; $display("FAIL fill_bresp got=%b exp=00 idx=%0d", r, i); end
    end
    exp_pcnt += 16;
    sb.push_back(32'h1010);
    @(posedge clk); #1;
    axil.s_axil_awaddr = 32'h0; axil.s_axil_wdata = 32'h1010; axil.s_axil_wstrb = 4'hF;
    axil.s_axil_awvalid = 1'b1; axil.s_axil_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!axil.s_axil_awready) stalled++;
    end
    checks++;
    if (stalled != 5) begin errors++; $display("FAIL stall_awready got=%0d_stalled exp=5_stalled", stalled); end
    axil_read(32'h4, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL stall_status got=%h/%b exp=00000000/00", d, r); end
    nbf_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axil.s_axil_awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axil.s_axil_awvalid = 1'b0; axil.s_axil_wvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_release got=stuck exp=accept"); end
    b_wait(r);
    exp_pcnt++;
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL stall_bresp got=%b exp=00", r); end
    wait_drain();
  endtask

  task automatic test_err();
    logic [1:0] r, rr;
    logic [31:0] d;
    nbf_ready = 1'b1;
    axil_write(32'h0, 32'hDEAD, 4'h3, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL partial_bresp got=%b exp=10", r); end
    axil_read(32'h4, d, r);
    checks++;
    if (d !== 32'h80000010) begin errors++; $display("FAIL err_status got=%h exp=80000010", d); end
    axil_write(32'hC, 32'h2, 4'hF, r);
    axil_read(32'h4, d, rr);
    checks += 2;
    if (r !== 2'b00) begin errors++; $display("FAIL clr_bresp got=%b exp=00", r); end
    if (d !== 32'h00000010) begin errors++; $display("FAIL clr_status got=%h exp=00000010", d); end
    axil_read(32'h6, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL unmapped_read got=%h/%b exp=0/10", d, r); end
    axil_read(32'h4, d, r);
    checks++;
    if (d !== 32'h80000010) begin errors++; $display("FAIL rd_err_status got=%h exp=80000010", d); end
    axil_write(32'hC, 32'h2, 4'hF, r);
    axil_write(32'h4, 32'hFFFFFFFF, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL ro_write_bresp got=%b exp=00", r); end
    axil_write(32'hE, 32'h1, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL unmapped_write got=%b exp=10", r); end
    axil_write(32'hC, 32'h2, 4'hF, r);
    axil_read(32'h4, d, r);
    checks++;
    if (d !== 32'h00000010) begin errors++; $display("FAIL reclr_status got=%h exp=00000010", d); end
    sb.push_back(32'hA5A50001);
    fork
      axil_write(32'h0, 32'hA5A50001, 4'hF, r);
      axil_read(32'h8, d, rr);
    join
    checks += 2;
    if (r !== 2'b00) begin errors++; $display("FAIL conc_bresp got=%b exp=00", r); end
    if (d !== 32'(exp_pcnt) || rr !== 2'b00) begin errors++; $display("FAIL conc_read got=%h/%b exp=%h/00", d, rr, exp_pcnt); end
    exp_pcnt++;
    axil_read(32'h8, d, r);
    checks++;
    if (d !== 32'(exp_pcnt)) begin errors++; $display("FAIL conc_pushcnt got=%h exp=%h", d, exp_pcnt); end
    wait_drain();
  endtask

  task automatic test_flush();
    bit ok;
    logic [1:0] r;
    logic [31:0] d;
    nbf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(32'h2000 + 32'(i));
      axil_write(32'h0, 32'h2000 + 32'(i), 4'hF, r);
    end
    exp_pcnt += 5;
    nbf_ready = 1'b1;
    aw_w(32'hC, 32'h1, 4'hF, ok);
    sb.delete();
    checks++;
    if (nbf_v !== 1'b0) begin errors++; $display("FAIL flush_v got=%b exp=0", nbf_v); end
    b_wait(r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL flush_bresp got=%b exp=00", r); end
    axil_read(32'h4, d, r);
    checks++;
    if (d !== 32'h00000010) begin errors++; $display("FAIL flush_status got=%h exp=00000010", d); end
    axil_read(32'h8, d, r);
    checks++;
    if (d !== 32'(exp_pcnt)) begin errors++; $display("FAIL flush_pushcnt got=%h exp=%h", d, exp_pcnt); end
  endtask

  task automatic test_midreset();
    bit ok;
    logic [1:0] r;
    logic [31:0] d;
    nbf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h3000 + 32'(i));
      axil_write(32'h0, 32'h3000 + 32'(i), 4'hF, r);
    end
    aw_w(32'hC, 32'h0, 4'hF, ok);
    @(negedge clk);
    checks++;
    if (axil.s_axil_bvalid !== 1'b1 || nbf_v !== 1'b1) begin errors++; $display("FAIL pre_reset got=b%b/v%b exp=b1/v1", axil.s_axil_bvalid, nbf_v); end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks += 2;
    if (axil.s_axil_bvalid !== 1'b0) begin errors++; $display("FAIL async_bvalid got=%b exp=0", axil.s_axil_bvalid); end
    if (nbf_v !== 1'b0) begin errors++; $display("FAIL async_nbf_v got=%b exp=0", nbf_v); end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_pcnt = 0;
    axil_read(32'h8, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL post_rst_pushcnt got=%h exp=0", d); end
    axil_read(32'h4, d, r);
    checks++;
    if (d !== 32'h00000010) begin errors++; $display("FAIL post_rst_status got=%h exp=00000010", d); end
    nbf_ready = 1'b1;
    sb.push_back(32'h55);
    axil_write(32'h0, 32'h55, 4'hF, r);
    exp_pcnt++;
    axil_read(32'h8, d, r);
    checks += 2;
    if (r !== 2'b00) begin errors++; $display("FAIL post_rst_rresp got=%b exp=00", r); end
    if (d !== 32'(exp_pcnt)) begin errors++; $display("FAIL post_rst_pushcnt1 got=%h exp=%h", d, exp_pcnt); end
    wait_drain();
  endtask

  initial begin
    axil.s_axil_awaddr = '0; axil.s_axil_awprot = '0; axil.s_axil_awvalid = 1'b0;
    axil.s_axil_wdata = '0; axil.s_axil_wstrb = '0; axil.s_axil_wvalid = 1'b0;
    axil.s_axil_bready = 1'b0; axil.s_axil_araddr = '0; axil.s_axil_arprot = '0;
    axil.s_axil_arvalid = 1'b0; axil.s_axil_rready = 1'b0;
    nbf_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_flush();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
